vdma_s2mm_framer: RTL and testbench
===================================

# vdma_s2mm_framer

Source-side framer for the VDMA write (S2MM) path. It takes a raw pixel-beat stream with a frame-start strobe and produces an AXI4-Stream video stream: `tuser` on the first beat of each frame, `tlast` on the last beat of each line. Beats are buffered in a small FIFO so that downstream `tready` backpressure is absorbed. It is the counterpart of the MM2S output pacing controller: where that block consumes `tuser`/`tlast`, this one generates them.

## Interface
Parameters:
- `DATA_W`, 64: pixel-beat width.
- `FIFO_DEPTH`, 16: buffer depth. Must be a power of 2 and at least 4.
- `CNT_W`, 16: width of the row and column counters. Only the low `CNT_W` bits of the config inputs are used.

Ports:
- `s_axis_aclk`, in, 1: the single clock. All logic is in this domain.
- `s_axis_areset`, in, 1: asynchronous, active-high reset.
- `vdma_row`, in, 32: lines per frame. Sampled when a frame starts.
- `vdma_col`, in, 32: beats per line. Sampled when a frame starts.
- `in_vsync`, in, 1: one-cycle frame-start strobe.
- `in_valid`, in, 1: beat present. There is no ready signal on this side; the source never stalls.
- `in_data`, in, `DATA_W`: pixel beat.
- `m_axis_s2mm_tdata`, out, `DATA_W`: output data.
- `m_axis_s2mm_tvalid`, out, 1: output valid.
- `m_axis_s2mm_tready`, in, 1: output ready.
- `m_axis_s2mm_tuser`, out, 1: start of frame.
- `m_axis_s2mm_tlast`, out, 1: end of line.
- `frame_done`, out, 1: one-cycle pulse when the last beat of a frame is accepted downstream.
- `overflow`, out, 1: sticky flag, set when a beat is dropped.
- `short_frame_cnt`, out, 16: count of aborted frames. Saturates at 0xFFFF.
- `fifo_level`, out, $clog2(`FIFO_DEPTH`)+1: current FIFO occupancy.

## Operation
- Reset values:
  - state is WAIT_SOF.
  - all counters are 0.
  - the FIFO is empty.
  - `tvalid`, `tuser`, `tlast`, `frame_done` and `overflow` are 0.
  - `short_frame_cnt` is 0.
- Reset mid-frame discards all FIFO contents and all in-progress state.
- State machine:
  - **WAIT_SOF**: `in_valid` beats are discarded. This does not set `overflow`. On `in_vsync`:
    - latch `row_cfg = vdma_row[CNT_W-1:0]` and `col_cfg = vdma_col[CNT_W-1:0]`;
    - clear `col_cnt` and `row_cnt`;
    - arm `sof_pending`;
    - go to ACTIVE.
    - If either latched value is 0, stay in WAIT_SOF instead.
  - **ACTIVE**: each `in_valid` beat is tagged as follows:
    - `tuser = sof_pending`, after which `sof_pending` clears;
    - `tlast = (col_cnt == col_cfg-1)`;
    - `eof = tlast && (row_cnt == row_cfg-1)`.
    - Counter update:
      - `col_cnt` wraps to 0 on `tlast`, otherwise increments;
      - `row_cnt` increments on `tlast`;
      - the beat carrying `eof` returns the state to WAIT_SOF.
- FIFO word layout is {`eof`, `tlast`, `tuser`, `data`}, `DATA_W`+3 bits wide. Tagging happens on the write side.
- `in_vsync` and `in_valid` in the same cycle: vsync is processed first, so that beat is the first beat of the new frame and carries `tuser=1`.
- `in_vsync` while in ACTIVE, when the `eof` beat has not yet been written:
  - `short_frame_cnt` increments (saturating);
  - config is re-latched, counters reset and `sof_pending` re-armed;
  - the block stays in ACTIVE.
  - No synthetic `tlast` is inserted; partial-line beats already in the FIFO drain unchanged.
- Overflow: a beat is dropped if `in_valid` arrives while the FIFO is full and no pop happens that cycle.
  - The dropped beat still advances the counters, so line geometry is preserved.
  - `overflow` is set and clears only on reset.
- A push while full with a simultaneous pop is legal and does not count as overflow.
- `frame_done` pulses on `tvalid && tready` of a word whose `eof` bit is set.

## Timing
- Input to output latency is 1 cycle: a beat written at edge N shows `tvalid` from cycle N+1 when the FIFO was empty. The FIFO is first-word-fall-through with a registered output.
- Throughput is 1 beat per cycle while `tready` is high.
- While stalled, `tdata`, `tuser` and `tlast` hold stable until accepted.
- `tvalid` is never withdrawn before it is accepted.
- `tuser` and `tlast` are 0 whenever `tvalid` is 0.
- `fifo_level` updates the cycle after a push or pop.
- `frame_done` is registered and asserts the cycle after the accepting edge.

## Structure
- `vdma_pkg` holds:
  - the state enum (WAIT_SOF, ACTIVE);
  - the FIFO word field offsets (`TUSER_BIT`, `TLAST_BIT`, `EOF_BIT`, relative to `DATA_W`).
- Sub-module `vdma_sync_fifo`: a parameterised-width, first-word-fall-through synchronous FIFO with async active-high reset, exposing `full`, `empty` and `level`.
- The framer itself owns the FSM, the counters, tag generation and the status outputs.

## Test plan
- Geometry: `vdma_row=3`, `vdma_col=4`, one vsync, 12 beats, `tready=1`. Expect:
  - `tuser` only on beat 0;
  - `tlast` on beats 3, 7 and 11;
  - `frame_done` one cycle after beat 11 is accepted.
- Backpressure: same frame with `tready` toggling 1-0-0-1. Expect:
  - all 12 beats arrive in order;
  - outputs held stable during stalls;
  - `overflow=0`.
- Overflow: `FIFO_DEPTH=16`, `tready=0`, 20 beats pushed. Expect:
  - `fifo_level=16`;
  - `overflow=1`;
  - after release, 16 beats out, with `tlast` positions still consistent with `col_cnt`.
- Short frame: vsync, 5 of 12 beats, then vsync combined with a beat in the same cycle. Expect:
  - `short_frame_cnt=1`;
  - the second frame's first beat has `tuser=1`.
- Pre-frame and zero config: beats with no vsync are dropped and `overflow` stays 0. A vsync with `vdma_col=0` keeps the state in WAIT_SOF and produces no output.
- Reset mid-frame: assert `s_axis_areset` with 6 words buffered. Expect:
  - `tvalid=0` and `fifo_level=0` immediately;
  - the next vsync restarts the frame cleanly.

Source files
------------

// File: rtl/vdma_pkg.sv
// vdma_pkg: shared types and constants for the S2MM framer.
//   state_t      - framer FSM states
//   *_BIT        - tag bit offsets in a FIFO word, relative to DATA_W
//                  (word layout is {eof, tlast, tuser, data})
package vdma_pkg;

    typedef enum logic {
        WAIT_SOF = 1'b0,
        ACTIVE   = 1'b1
    } state_t;

    localparam int TUSER_BIT = 0;
    localparam int TLAST_BIT = 1;
    localparam int EOF_BIT   = 2;
    localparam int TAG_W     = 3;

endpackage

// File: rtl/vdma_s2mm_framer_if.sv
// vdma_s2mm_framer_if: AXI4-Stream video channel (tdata/tvalid/tready/tuser/tlast).
//   master - stream producer (the framer)
//   slave  - stream consumer (the VDMA write port)
interface vdma_s2mm_framer_if #(
    parameter int DATA_W = 64
);
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tuser;
    logic              tlast;

    modport master (output tdata, tvalid, tuser, tlast, input tready);
    modport slave  (input tdata, tvalid, tuser, tlast, output tready);
endinterface

// File: rtl/vdma_sync_fifo.sv
// vdma_sync_fifo: first-word-fall-through synchronous FIFO.
//   clk, rst  - clock, async active-high reset (empties the FIFO)
//   i_push    - write request; ignored when full unless a pop happens the same cycle
//   i_wdata   - write word
//   i_pop     - read request; ignored when empty
//   o_rdata   - head word, valid whenever o_empty is low
//   o_full, o_empty, o_level - occupancy status, all derived from registered state
module vdma_sync_fifo #(
    parameter  int WIDTH = 67,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty,
    output logic [LW-1:0]    o_level
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic             w_push;
    logic             w_pop;

    assign o_empty = (r_level == '0);
    assign o_full  = (r_level == LW'(DEPTH));
    assign o_level = r_level;
    assign o_rdata = r_mem[r_rd_ptr];

    // A pop frees the slot at the same edge, so push-while-full is allowed then.
    // When full, wr_ptr == rd_ptr: the head is overwritten exactly as it leaves.
    assign w_pop  = i_pop && !o_empty;
    assign w_push = i_push && (!o_full || w_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_level <= r_level + LW'(w_push) - LW'(w_pop);
        end
    end

    // Storage needs no reset: the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wdata;
    end

endmodule

// File: rtl/vdma_s2mm_framer.sv
// vdma_s2mm_framer: tags a raw pixel-beat stream with AXI4-Stream video
// sideband (tuser = start of frame, tlast = end of line) and buffers it in a
// FIFO to absorb downstream backpressure.
//   s_axis_aclk, s_axis_areset - clock, async active-high reset
//   vdma_row, vdma_col         - lines per frame / beats per line, latched at vsync
//   in_vsync, in_valid, in_data - source stream (never stalls)
//   m_axis_s2mm                - AXI4-Stream master output
//   frame_done                 - pulse after the end-of-frame beat is accepted
//   overflow                   - sticky: a beat was dropped on a full FIFO
//   short_frame_cnt            - saturating count of frames cut short by vsync
//   fifo_level                 - FIFO occupancy
module vdma_s2mm_framer #(
    parameter  int DATA_W     = 64,
    parameter  int FIFO_DEPTH = 16,
    parameter  int CNT_W      = 16,
    localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic               s_axis_aclk,
    input  logic               s_axis_areset,
    input  logic [31:0]        vdma_row,
    input  logic [31:0]        vdma_col,
    input  logic               in_vsync,
    input  logic               in_valid,
    input  logic [DATA_W-1:0]  in_data,
    vdma_s2mm_framer_if.master m_axis_s2mm,
    output logic               frame_done,
    output logic               overflow,
    output logic [15:0]        short_frame_cnt,
    output logic [LVL_W-1:0]   fifo_level
);
    import vdma_pkg::*;

    localparam int WORD_W = DATA_W + TAG_W;

    state_t             r_state;
    logic [CNT_W-1:0]   r_row_cfg, r_col_cfg, r_row_cnt, r_col_cnt;
    logic               r_sof;
    logic               r_frame_done;
    logic               r_overflow;
    logic [15:0]        r_short_cnt;

    logic [CNT_W-1:0]   w_new_row, w_new_col;
    logic [CNT_W-1:0]   w_row_cfg, w_col_cfg, w_row_cnt, w_col_cnt;
    logic               w_sof, w_active, w_beat, w_tlast, w_eof;
    logic [WORD_W-1:0]  w_word, w_rdata;
    logic               w_full, w_empty, w_pop;

    assign w_new_row = vdma_row[CNT_W-1:0];
    assign w_new_col = vdma_col[CNT_W-1:0];

    generate
        if (CNT_W < 32) begin : g_cfg_hi
            logic w_unused_cfg_hi;
            assign w_unused_cfg_hi = ^{vdma_row[31:CNT_W], vdma_col[31:CNT_W]};
        end
    endgenerate

    // vsync takes effect before a beat in the same cycle: the "effective"
    // config/counters below are what that beat is tagged against.
    always_comb begin
        w_row_cfg = r_row_cfg;
        w_col_cfg = r_col_cfg;
        w_row_cnt = r_row_cnt;
        w_col_cnt = r_col_cnt;
        w_sof     = r_sof;
        w_active  = (r_state == ACTIVE);
        if (in_vsync) begin
            w_row_cfg = w_new_row;
            w_col_cfg = w_new_col;
            w_row_cnt = '0;
            w_col_cnt = '0;
            w_sof     = 1'b1;
            w_active  = (w_new_row != '0) && (w_new_col != '0);
        end
        w_beat  = in_valid && w_active;
        w_tlast = (w_col_cnt == w_col_cfg - CNT_W'(1));
        w_eof   = w_tlast && (w_row_cnt == w_row_cfg - CNT_W'(1));
        w_word  = {w_eof, w_tlast, w_sof, in_data};
    end

    assign w_pop = !w_empty && m_axis_s2mm.tready;

    vdma_sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (s_axis_aclk),
        .rst     (s_axis_areset),
        .i_push  (w_beat),
        .i_wdata (w_word),
        .i_pop   (m_axis_s2mm.tready),
        .o_rdata (w_rdata),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (fifo_level)
    );

    always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
        if (s_axis_areset) begin
            r_state      <= WAIT_SOF;
            r_row_cfg    <= '0;
            r_col_cfg    <= '0;
            r_row_cnt    <= '0;
            r_col_cnt    <= '0;
            r_sof        <= 1'b0;
            r_frame_done <= 1'b0;
            r_overflow   <= 1'b0;
            r_short_cnt  <= '0;
        end else begin
            r_frame_done <= w_pop && w_rdata[DATA_W+EOF_BIT];
            r_row_cfg    <= w_row_cfg;
            r_col_cfg    <= w_col_cfg;

            // In ACTIVE the eof beat has not been written yet, so any vsync aborts.
            if (in_vsync && r_state == ACTIVE && r_short_cnt != 16'hFFFF)
                r_short_cnt <= r_short_cnt + 16'd1;

            // Dropped beats still advance the counters so line geometry holds.
            if (w_beat && w_full && !w_pop)
                r_overflow <= 1'b1;

            if (w_beat) begin
                r_sof <= 1'b0;
                if (w_tlast) begin
                    r_col_cnt <= '0;
                    r_row_cnt <= w_row_cnt + CNT_W'(1);
                end else begin
                    r_col_cnt <= w_col_cnt + CNT_W'(1);
                    r_row_cnt <= w_row_cnt;
                end
                r_state <= w_eof ? WAIT_SOF : ACTIVE;
            end else begin
                r_sof     <= w_sof;
                r_col_cnt <= w_col_cnt;
                r_row_cnt <= w_row_cnt;
                r_state   <= w_active ? ACTIVE : WAIT_SOF;
            end
        end
    end

    assign m_axis_s2mm.tvalid = !w_empty;
    assign m_axis_s2mm.tdata  = w_rdata[DATA_W-1:0];
    assign m_axis_s2mm.tuser  = !w_empty && w_rdata[DATA_W+TUSER_BIT];
    assign m_axis_s2mm.tlast  = !w_empty && w_rdata[DATA_W+TLAST_BIT];

    assign frame_done      = r_frame_done;
    assign overflow        = r_overflow;
    assign short_frame_cnt = r_short_cnt;

endmodule

// File: tb/tb_vdma_s2mm_framer.sv
module tb_vdma_s2mm_framer;
    localparam int DW    = 64;
    localparam int DEPTH = 16;
    localparam int LW    = 5;

    typedef logic [DW+1:0] rec_t;   // {tlast, tuser, data}
    typedef logic [DW+2:0] mword_t; // {eof, tlast, tuser, data}

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [31:0]   vrow = '0, vcol = '0;
    logic          vsync = 1'b0, valid = 1'b0;
    logic [DW-1:0] din = '0;
    logic          frame_done, overflow;
    logic [15:0]   short_cnt;
    logic [LW-1:0] level;

    vdma_s2mm_framer_if #(.DATA_W(DW)) axis();

    vdma_s2mm_framer #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .CNT_W(16)) dut (
        .s_axis_aclk     (clk),
        .s_axis_areset   (rst),
        .vdma_row        (vrow),
        .vdma_col        (vcol),
        .in_vsync        (vsync),
        .in_valid        (valid),
        .in_data         (din),
        .m_axis_s2mm     (axis),
        .frame_done      (frame_done),
        .overflow        (overflow),
        .short_frame_cnt (short_cnt),
        .fifo_level      (level)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_err = 0;

    // Monitor: sampled on the falling edge, away from the active edge.
    rec_t rx[$];
    int   cyc = 0, done_cnt = 0, last_acc = -1, done_cyc = -1;
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            rx.delete();
            done_cnt = 0;
        end else begin
            if (axis.tvalid && axis.tready) begin
                rx.push_back({axis.tlast, axis.tuser, axis.tdata});
                last_acc = cyc;
            end
            if (frame_done) begin
                done_cnt = done_cnt + 1;
                done_cyc = cyc;
            end
        end
    end

    // Reference model: frame position as a flat beat index k within the frame.
    mword_t m_q[$];
    rec_t   m_out[$];
    bit     m_act, m_ovf, m_pop;
    int     m_k, m_rows, m_cols, m_short, m_done, m_occ, m_last;
    mword_t m_w;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q.delete(); m_out.delete();
            m_act = 0; m_ovf = 0; m_k = 0; m_rows = 0; m_cols = 0;
            m_short = 0; m_done = 0;
        end else begin
            m_occ = m_q.size();
            m_pop = (m_occ > 0) && axis.tready;
            if (m_pop) begin
                m_w = m_q.pop_front();
                m_out.push_back(m_w[DW+1:0]);
                if (m_w[DW+2]) m_done = m_done + 1;
            end
            if (vsync) begin
                if (m_act && m_short < 65535) m_short = m_short + 1;
                m_rows = int'(vrow[15:0]);
                m_cols = int'(vcol[15:0]);
                m_act  = (m_rows != 0) && (m_cols != 0);
                m_k    = 0;
            end
            if (valid && m_act) begin
                m_last = m_rows * m_cols - 1;
                m_w = {m_k == m_last, (m_k % m_cols) == m_cols - 1, m_k == 0, din};
                if (m_occ < DEPTH || m_pop) m_q.push_back(m_w);
                else m_ovf = 1;
                if (m_k == m_last) m_act = 0;
                m_k = m_k + 1;
            end
        end
    end

    task automatic step(input logic vs, input logic v, input logic [DW-1:0] d, input logic rdy);
        vsync = vs; valid = v; din = d; axis.tready = rdy;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n, input logic rdy);
        repeat (n) step(1'b0, 1'b0, '0, rdy);
    endtask

    task automatic do_reset();
        vsync = 0; valid = 0; rst = 1;
        @(negedge clk); @(posedge clk); #1;
        rst = 0;
    endtask

    function automatic logic [DW-1:0] rnd();
        return {$urandom, $urandom};
    endfunction

    task automatic test_reset();
        axis.tready = 0;
        rst = 1; #1;
        n_cmp++; if (axis.tvalid !== 1'b0) begin n_err++; $display("FAIL reset_tvalid got %b want 0", axis.tvalid); end
        n_cmp++; if (axis.tuser !== 1'b0) begin n_err++; $display("FAIL reset_tuser got %b want 0", axis.tuser); end
        n_cmp++; if (axis.tlast !== 1'b0) begin n_err++; $display("FAIL reset_tlast got %b want 0", axis.tlast); end
        n_cmp++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL reset_frame_done got %b want 0", frame_done); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow got %b want 0", overflow); end
        n_cmp++; if (short_cnt !== 16'd0) begin n_err++; $display("FAIL reset_short got %0d want 0", short_cnt); end
        n_cmp++; if (level !== 5'd0) begin n_err++; $display("FAIL reset_level got %0d want 0", level); end
        @(negedge clk); @(posedge clk); #1;
        rst = 0;
    endtask

    task automatic test_geometry();
        logic [DW-1:0] exp_d[12];
        rec_t want;
        do_reset();
        vrow = 3; vcol = 4;
        step(1, 0, '0, 1);
        for (int i = 0; i < 12; i++) begin
            exp_d[i] = rnd();
            step(0, 1, exp_d[i], 1);
        end
        idle(4, 1);
        n_cmp++; if (rx.size() != 12) begin n_err++; $display("FAIL geom_count got %0d want 12", rx.size()); end
        for (int i = 0; i < 12 && i < rx.size(); i++) begin
            want = {(i % 4) == 3, i == 0, exp_d[i]};
            n_cmp++; if (rx[i] !== want) begin n_err++; $display("FAIL geom_beat%0d got %h want %h", i, rx[i], want); end
        end
        n_cmp++; if (done_cnt != 1) begin n_err++; $display("FAIL geom_done_cnt got %0d want 1", done_cnt); end
        n_cmp++; if (done_cyc != last_acc + 1) begin n_err++; $display("FAIL geom_done_timing got %0d want %0d", done_cyc, last_acc + 1); end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] exp_d[12];
        logic [3:0] pat;
        logic prev_v, prev_acc;
        logic [DW+1:0] prev, cur;
        rec_t want;
        pat = 4'b1001;
        do_reset();
        vrow = 3; vcol = 4;
        prev_v = 0; prev_acc = 0; prev = '0;
        for (int c = 0; c < 48; c++) begin
            vsync = (c == 0);
            valid = (c >= 1 && c <= 12);
            if (c >= 1 && c <= 12) begin exp_d[c-1] = rnd(); din = exp_d[c-1]; end
            else din = '0;
            axis.tready = pat[c % 4];
            @(negedge clk);
            cur = {axis.tlast, axis.tuser, axis.tdata};
            if (prev_v && !prev_acc) begin
                n_cmp++; if (!axis.tvalid || cur !== prev) begin n_err++; $display("FAIL bp_stable cyc %0d got %b/%h want 1/%h", c, axis.tvalid, cur, prev); end
            end
            if (!axis.tvalid) begin
                n_cmp++; if (axis.tuser || axis.tlast) begin n_err++; $display("FAIL bp_idle_tags got %b%b want 00", axis.tuser, axis.tlast); end
            end
            prev_v = axis.tvalid; prev_acc = axis.tvalid && axis.tready; prev = cur;
            @(posedge clk); #1;
        end
        vsync = 0; valid = 0;
        n_cmp++; if (rx.size() != 12) begin n_err++; $display("FAIL bp_count got %0d want 12", rx.size()); end
        for (int i = 0; i < 12 && i < rx.size(); i++) begin
            want = {(i % 4) == 3, i == 0, exp_d[i]};
            n_cmp++; if (rx[i] !== want) begin n_err++; $display("FAIL bp_beat%0d got %h want %h", i, rx[i], want); end
        end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL bp_overflow got %b want 0", overflow); end
    endtask

    task automatic test_overflow();
        logic [DW-1:0] exp_d[24];
        rec_t want;
        do_reset();
        vrow = 2; vcol = 12;
        step(1, 0, '0, 0);
        for (int i = 0; i < 20; i++) begin exp_d[i] = rnd(); step(0, 1, exp_d[i], 0); end
        idle(1, 0);
        n_cmp++; if (level !== 5'd16) begin n_err++; $display("FAIL ovf_level got %0d want 16", level); end
        n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag got %b want 1", overflow); end
        idle(20, 1);
        n_cmp++; if (rx.size() != 16) begin n_err++; $display("FAIL ovf_count got %0d want 16", rx.size()); end
        for (int i = 0; i < 16 && i < rx.size(); i++) begin
            want = {i == 11, i == 0, exp_d[i]};
            n_cmp++; if (rx[i] !== want) begin n_err++; $display("FAIL ovf_beat%0d got %h want %h", i, rx[i], want); end
        end
        // Beats 16..19 were dropped but counted; k=20..23 finish the frame.
        for (int i = 20; i < 24; i++) begin exp_d[i] = rnd(); step(0, 1, exp_d[i], 1); end
        idle(4, 1);
        n_cmp++; if (rx.size() != 20) begin n_err++; $display("FAIL ovf_tail_count got %0d want 20", rx.size()); end
        for (int j = 0; j < 4 && 16 + j < rx.size(); j++) begin
            want = {j == 3, 1'b0, exp_d[20+j]};
            n_cmp++; if (rx[16+j] !== want) begin n_err++; $display("FAIL ovf_tail%0d got %h want %h", j, rx[16+j], want); end
        end
        n_cmp++; if (done_cnt != 1) begin n_err++; $display("FAIL ovf_done got %0d want 1", done_cnt); end
        n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky got %b want 1", overflow); end
    endtask

    task automatic test_short_frame();
        logic [DW-1:0] exp_d[17];
        rec_t want;
        int j;
        do_reset();
        vrow = 3; vcol = 4;
        step(1, 0, '0, 1);
        for (int i = 0; i < 5; i++) begin exp_d[i] = rnd(); step(0, 1, exp_d[i], 1); end
        exp_d[5] = rnd(); step(1, 1, exp_d[5], 1);
        for (int i = 6; i < 17; i++) begin exp_d[i] = rnd(); step(0, 1, exp_d[i], 1); end
        idle(4, 1);
        n_cmp++; if (short_cnt !== 16'd1) begin n_err++; $display("FAIL short_cnt got %0d want 1", short_cnt); end
        n_cmp++; if (rx.size() != 17) begin n_err++; $display("FAIL short_count got %0d want 17", rx.size()); end
        for (int i = 0; i < 17 && i < rx.size(); i++) begin
            j = (i < 5) ? i : i - 5;
            want = {(j % 4) == 3, j == 0, exp_d[i]};
            n_cmp++; if (rx[i] !== want) begin n_err++; $display("FAIL short_beat%0d got %h want %h", i, rx[i], want); end
        end
        n_cmp++; if (done_cnt != 1) begin n_err++; $display("FAIL short_done got %0d want 1", done_cnt); end
    endtask

    task automatic test_zero_cfg();
        do_reset();
        for (int i = 0; i < 5; i++) step(0, 1, rnd(), 1);
        vrow = 3; vcol = 0;
        step(1, 1, rnd(), 1);
        for (int i = 0; i < 4; i++) step(0, 1, rnd(), 1);
        idle(2, 1);
        n_cmp++; if (rx.size() != 0) begin n_err++; $display("FAIL zero_out got %0d want 0", rx.size()); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL zero_overflow got %b want 0", overflow); end
        n_cmp++; if (level !== 5'd0) begin n_err++; $display("FAIL zero_level got %0d want 0", level); end
        n_cmp++; if (short_cnt !== 16'd0) begin n_err++; $display("FAIL zero_short got %0d want 0", short_cnt); end
        vrow = 1; vcol = 2;
        step(1, 0, '0, 1);
        step(0, 1, rnd(), 1); step(0, 1, rnd(), 1);
        idle(3, 1);
        n_cmp++; if (rx.size() != 2) begin n_err++; $display("FAIL zero_recover got %0d want 2", rx.size()); end
    endtask

    task automatic test_reset_midframe();
        logic [DW-1:0] exp_d[3];
        rec_t want;
        do_reset();
        vrow = 3; vcol = 4;
        step(1, 0, '0, 0);
        for (int i = 0; i < 6; i++) step(0, 1, rnd(), 0);
        n_cmp++; if (level !== 5'd6) begin n_err++; $display("FAIL rstmid_level_pre got %0d want 6", level); end
        rst = 1; #1;
        n_cmp++; if (axis.tvalid !== 1'b0) begin n_err++; $display("FAIL rstmid_tvalid got %b want 0", axis.tvalid); end
        n_cmp++; if (level !== 5'd0) begin n_err++; $display("FAIL rstmid_level got %0d want 0", level); end
        @(negedge clk); @(posedge clk); #1;
        rst = 0;
        vrow = 1; vcol = 3;
        exp_d[0] = rnd(); step(1, 1, exp_d[0], 1);
        for (int i = 1; i < 3; i++) begin exp_d[i] = rnd(); step(0, 1, exp_d[i], 1); end
        idle(4, 1);
        n_cmp++; if (rx.size() != 3) begin n_err++; $display("FAIL rstmid_count got %0d want 3", rx.size()); end
        for (int i = 0; i < 3 && i < rx.size(); i++) begin
            want = {i == 2, i == 0, exp_d[i]};
            n_cmp++; if (rx[i] !== want) begin n_err++; $display("FAIL rstmid_beat%0d got %h want %h", i, rx[i], want); end
        end
        n_cmp++; if (done_cnt != 1) begin n_err++; $display("FAIL rstmid_done got %0d want 1", done_cnt); end
    endtask

    task automatic test_random();
        logic vs, v, r;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            vs = ($urandom_range(0, 29) == 0);
            if (vs) begin
                vrow = ($urandom_range(0, 9) == 0) ? 32'd0 : 32'($urandom_range(1, 3));
                vcol = ($urandom_range(0, 9) == 0) ? 32'd0 : 32'($urandom_range(1, 6));
            end
            v = ($urandom_range(0, 3) != 0);
            r = (c < 1500) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 1) != 0);
            step(vs, v, rnd(), r);
        end
        idle(40, 1);
        n_cmp++; if (rx.size() != m_out.size()) begin n_err++; $display("FAIL rand_count got %0d want %0d", rx.size(), m_out.size()); end
        for (int i = 0; i < rx.size() && i < m_out.size(); i++) begin
            n_cmp++;
            if (rx[i] !== m_out[i]) begin
                n_err++; $display("FAIL rand_beat%0d got %h want %h", i, rx[i], m_out[i]);
                break;
            end
        end
        n_cmp++; if (overflow !== m_ovf) begin n_err++; $display("FAIL rand_overflow got %b want %b", overflow, m_ovf); end
        n_cmp++; if (short_cnt !== 16'(m_short)) begin n_err++; $display("FAIL rand_short got %0d want %0d", short_cnt, m_short); end
        n_cmp++; if (done_cnt != m_done) begin n_err++; $display("FAIL rand_done got %0d want %0d", done_cnt, m_done); end
        n_cmp++; if (level !== 5'd0) begin n_err++; $display("FAIL rand_level got %0d want 0", level); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_geometry();
        test_backpressure();
        test_overflow();
        test_short_frame();
        test_zero_cfg();
        test_reset_midframe();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
